// File: rtl/fmul_seq.sv
// Multi-cycle IEEE-754 single-precision multiplier: radix-2 shift-add mantissa product,
// round-half-up, denormals flushed to zero, valid/ready on both sides.
module fmul_seq #(
  parameter int EXP_W    = 8,
  parameter int FRAC_W   = 23,
  parameter int EXP_BIAS = 127
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              A_sign,
  input  logic [EXP_W-1:0]  A_exp,
  input  logic [FRAC_W-1:0] A_frac,
  input  logic              B_sign,
  input  logic [EXP_W-1:0]  B_exp,
  input  logic [FRAC_W-1:0] B_frac,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign,
  output logic [EXP_W-1:0]  exp,
  output logic [FRAC_W-1:0] frac,
  output logic              error,
  output logic              overflow,
  output logic [1:0]        dbg_state_o
);

  // Handshake: an operand pair transfers on a rising edge with in_valid & in_ready;
  // a result transfers on a rising edge with out_valid & out_ready. out_valid holds
  // and outputs stay stable until that transfer.

  localparam int MW = FRAC_W + 1;
  localparam int PW = 2 * MW;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(MW);
  localparam int EXP_MAX = (1 << EXP_W) - 1;
  localparam logic [FRAC_W-1:0] FRAC_NAN = {1'b1, {(FRAC_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_NORM, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [MW-1:0]     mplier_q, mplier_d;
  logic [EW-1:0]     esum_q, esum_d;
  logic              sign_q, sign_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;

  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic is_nan, is_inf, is_zero;

  assign a_zero = (A_exp == '0);
  assign a_inf  = (A_exp == '1) && (A_frac == '0);
  assign a_nan  = (A_exp == '1) && (A_frac != '0);
  assign b_zero = (B_exp == '0);
  assign b_inf  = (B_exp == '1) && (B_frac == '0);
  assign b_nan  = (B_exp == '1) && (B_frac != '0);
  assign is_nan  = a_nan | b_nan | (a_zero & b_inf) | (a_inf & b_zero);
  assign is_inf  = a_inf | b_inf;
  assign is_zero = a_zero | b_zero;

  // Normalisation and rounding of the finished product
  logic [FRAC_W-1:0] mant;
  logic              guard;
  logic              e_inc;
  logic [FRAC_W:0]   rsum;
  logic              carry;
  logic [EW-1:0]     e_norm;
  logic              e_over, e_under;

  always_comb begin
    mant  = '0;
    guard = 1'b0;
    e_inc = 1'b0;
    if (acc_q[PW-1]) begin
      mant  = acc_q[PW-2 -: FRAC_W];
      guard = acc_q[PW-2-FRAC_W];
      e_inc = 1'b1;
    end else begin
      mant  = acc_q[PW-3 -: FRAC_W];
      guard = acc_q[PW-3-FRAC_W];
    end
    rsum   = {1'b0, mant} + {{FRAC_W{1'b0}}, guard};
    carry  = rsum[FRAC_W];
    // Two's-complement wrap in EW bits; MSB acts as the sign.
    e_norm = esum_q - EW'(EXP_BIAS) + EW'(e_inc) + EW'(carry);
    e_over  = !e_norm[EW-1] && (e_norm >= EW'(EXP_MAX));
    e_under = e_norm[EW-1] || (e_norm == '0);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    esum_d   = esum_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    frac_d   = frac_q;
    err_d    = err_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d = A_sign ^ B_sign;
          err_d  = 1'b0;
          ovf_d  = 1'b0;
          if (is_nan) begin
            exp_d   = '1;
            frac_d  = FRAC_NAN;
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (is_inf) begin
            exp_d   = '1;
            frac_d  = '0;
            ovf_d   = 1'b1;
            state_d = S_DONE;
          end else if (is_zero) begin
            exp_d   = '0;
            frac_d  = '0;
            state_d = S_DONE;
          end else begin
            acc_d    = '0;
            mcand_d  = {{MW{1'b0}}, 1'b1, A_frac};
            mplier_d = {1'b1, B_frac};
            esum_d   = EW'(A_exp) + EW'(B_exp);
            cnt_d    = '0;
            state_d  = S_MUL;
          end
        end
      end
      S_MUL: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(MW-1)) state_d = S_NORM;
      end
      S_NORM: begin
        if (e_over) begin
          exp_d  = '1;
          frac_d = '0;
          ovf_d  = 1'b1;
        end else if (e_under) begin
          exp_d  = '0;
          frac_d = '0;
        end else begin
          exp_d  = e_norm[EXP_W-1:0];
          frac_d = carry ? '0 : rsum[FRAC_W-1:0];
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      esum_q   <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      frac_q   <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      esum_q   <= esum_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      frac_q   <= frac_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign sign        = sign_q;
  assign exp         = exp_q;
  assign frac        = frac_q;
  assign error       = err_q;
  assign overflow    = ovf_q;
  assign dbg_state_o = state_q;

endmodule
